dmem_responder: RTL and testbench

//  Data-memory responder: the target side of the processor's load/store port.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store port between a multicycle core (master) and its data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  busy, resp_valid, rdata, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output busy, resp_valid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY cycles from accept to sample,
// byte/half/word loads and stores with sign/zero extension and fault detection.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            r_err_pend;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_acc_err;
  logic            w_sel_we;
  logic            w_sel_err;
  logic [2:0]      w_sel_f3;
  logic [AW+1:0]   w_sel_addr;
  logic [31:0]     w_rd_word;
  logic            w_busy;
  logic            w_resp_valid;

  function automatic logic f_access_err(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic e;
    case (f3)
      3'b000, 3'b100: e = 1'b0;
      3'b001, 3'b101: e = addr[0];
      3'b010:         e = (addr[1:0] != 2'b00);
      default:        e = 1'b1;
    endcase
    return e | (we & f3[2]) | ({2'b00, addr[31:2]} >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      2'b10:   r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && bus.req;
  assign w_acc_err = f_access_err(bus.we, bus.funct3, bus.addr);

  // RESP is entered straight from IDLE only when LATENCY==1, so pick live inputs there.
  assign w_sel_we   = (r_state == S_IDLE) ? bus.we             : r_we;
  assign w_sel_f3   = (r_state == S_IDLE) ? bus.funct3         : r_f3;
  assign w_sel_addr = (r_state == S_IDLE) ? bus.addr[AW+1:0]   : r_addr;
  assign w_sel_err  = (r_state == S_IDLE) ? w_acc_err          : r_err_pend;
  assign w_rd_word  = r_mem[w_sel_addr[AW+1:2]];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        else          w_state_next = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_next = S_RESP;
        else               w_state_next = S_WAIT;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy       = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE:  begin w_busy = 1'b0; w_resp_valid = 1'b0; end
      S_WAIT:  begin w_busy = 1'b1; w_resp_valid = 1'b0; end
      S_RESP:  begin w_busy = 1'b1; w_resp_valid = 1'b1; end
      default: begin w_busy = 1'b0; w_resp_valid = 1'b0; end
    endcase
  end

  // Wait counter
  always_ff @(posedge i_clk) begin
    if (i_reset)                                 r_cnt <= 4'd0;
    else if (w_accept)                           r_cnt <= CNT_INIT;
    else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Request capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we       <= 1'b0;
      r_f3       <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_err_pend <= 1'b0;
    end else if (w_accept) begin
      r_we       <= bus.we;
      r_f3       <= bus.funct3;
      r_addr     <= bus.addr[AW+1:0];
      r_wdata    <= bus.wdata;
      r_err_pend <= w_acc_err;
    end
  end

  // Response data: loaded on RESP entry, cleared on exit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_state_next == S_RESP) begin
      r_err   <= w_sel_err;
      r_rdata <= (w_sel_err || w_sel_we) ? 32'd0 : f_load(w_rd_word, w_sel_f3, w_sel_addr[1:0]);
    end else if (r_state == S_RESP) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Store commit on the RESP exit edge; storage itself is never reset
  always_ff @(posedge i_clk) begin
    if (!i_reset && r_state == S_RESP && r_we && !r_err_pend)
      r_mem[r_addr[AW+1:2]] <= f_store(r_mem[r_addr[AW+1:2]], r_wdata, r_f3, r_addr[1:0]);
  end

  assign bus.busy       = w_busy;
  assign bus.resp_valid = w_resp_valid;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder at LATENCY=2 and LATENCY=1 against a byte-level model.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        drv_req  [2];
  logic        drv_we   [2];
  logic [2:0]  drv_f3   [2];
  logic [31:0] drv_addr [2];
  logic [31:0] drv_wd   [2];

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  assign bus0.req    = drv_req[0];
  assign bus0.we     = drv_we[0];
  assign bus0.funct3 = drv_f3[0];
  assign bus0.addr   = drv_addr[0];
  assign bus0.wdata  = drv_wd[0];
  assign bus1.req    = drv_req[1];
  assign bus1.we     = drv_we[1];
  assign bus1.funct3 = drv_f3[1];
  assign bus1.addr   = drv_addr[1];
  assign bus1.wdata  = drv_wd[1];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0.slave));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles left in the current access (0 = idle), the access itself, and byte memory
  int          m_left  [2] = '{0, 0};
  bit          m_we    [2];
  bit          m_err   [2];
  logic [2:0]  m_f3    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wd    [2];
  logic [31:0] m_rdata [2];
  logic [7:0]  m_mem   [2][4*DEPTH];

  function automatic int lat(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit mdl_err(bit we, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (we && f3 >= 3'b100) return 1'b1;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdl_edge(int i);
    int sz;
    logic [31:0] v;
    if (rst) begin
      m_left[i] = 0;
    end else if (m_left[i] > 0) begin
      m_left[i] = m_left[i] - 1;
      if (m_left[i] == 0 && m_we[i] && !m_err[i]) begin
        sz = 1 << m_f3[i][1:0];
        for (int b = 0; b < sz; b++) m_mem[i][m_addr[i] + b] = 8'(m_wd[i] >> (8 * b));
      end
    end else if (drv_req[i]) begin
      m_left[i]  = lat(i);
      m_we[i]    = drv_we[i];
      m_f3[i]    = drv_f3[i];
      m_addr[i]  = drv_addr[i];
      m_wd[i]    = drv_wd[i];
      m_err[i]   = mdl_err(drv_we[i], drv_f3[i], drv_addr[i]);
      m_rdata[i] = 32'd0;
      if (!m_err[i] && !drv_we[i]) begin
        sz = 1 << drv_f3[i][1:0];
        v = 32'd0;
        for (int b = 0; b < sz; b++) v = v | (32'(m_mem[i][drv_addr[i] + b]) << (8 * b));
        if (!drv_f3[i][2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        m_rdata[i] = v;
      end
    end
  endtask

  function automatic logic d_busy(int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic d_rv(int i);
    return (i == 0) ? bus0.resp_valid : bus1.resp_valid;
  endfunction
  function automatic logic [31:0] d_rdata(int i);
    return (i == 0) ? bus0.rdata : bus1.rdata;
  endfunction
  function automatic logic d_err(int i);
    return (i == 0) ? bus0.err : bus1.err;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[lat%0d] actual=%h expected=%h t=%0t", nm, lat(i), act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit rv;
    for (int i = 0; i < 2; i++) begin
      rv = (m_left[i] == 1);
      chk("busy",       i, 32'(d_busy(i)), 32'(m_left[i] > 0));
      chk("resp_valid", i, 32'(d_rv(i)),   32'(rv));
      chk("rdata",      i, d_rdata(i),     rv ? m_rdata[i] : 32'd0);
      chk("err",        i, 32'(d_err(i)),  32'(rv && m_err[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge(0);
    mdl_edge(1);
    @(negedge clk);
    check_all();
  endtask

  // Issue one access, run to its response, optionally pin literal results, then finish the exit edge.
  task automatic do_req(int i, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                        bit lit, logic [31:0] lit_rd, bit lit_err);
    drv_req[i] = 1'b1; drv_we[i] = we; drv_f3[i] = f3; drv_addr[i] = a; drv_wd[i] = wd;
    step();
    drv_req[i] = 1'b0;
    for (int n = 0; n < 20 && m_left[i] > 1; n++) step();
    if (lit) begin
      chk("lit_resp_valid", i, 32'(d_rv(i)),  32'd1);
      chk("lit_rdata",      i, d_rdata(i),    lit_rd);
      chk("lit_err",        i, 32'(d_err(i)), 32'(lit_err));
    end
    step();
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_req[i] = 1'b0; drv_we[i] = 1'b0; drv_f3[i] = 3'd0; drv_addr[i] = 32'd0; drv_wd[i] = 32'd0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    // Fill both memories so later loads never see unwritten words
    for (int w = 0; w < DEPTH; w++) begin
      do_req(0, 1'b1, 3'b010, 32'(4 * w), $urandom, 1'b0, 32'd0, 1'b0);
      do_req(1, 1'b1, 3'b010, 32'(4 * w), $urandom, 1'b0, 32'd0, 1'b0);
    end

    do_req(0, 1'b1, 3'b010, 32'h64, 32'd25,          1'b1, 32'h0000_0000, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h64, 32'd0,           1'b1, 32'h0000_0019, 1'b0);
    do_req(0, 1'b1, 3'b010, 32'h60, 32'h1122_3344,   1'b1, 32'h0000_0000, 1'b0);
    do_req(0, 1'b1, 3'b000, 32'h61, 32'h0000_00AB,   1'b1, 32'h0000_0000, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h60, 32'd0,           1'b1, 32'h1122_AB44, 1'b0);
    do_req(0, 1'b0, 3'b000, 32'h61, 32'd0,           1'b1, 32'hFFFF_FFAB, 1'b0);
    do_req(0, 1'b0, 3'b100, 32'h61, 32'd0,           1'b1, 32'h0000_00AB, 1'b0);
    do_req(0, 1'b0, 3'b001, 32'h62, 32'd0,           1'b1, 32'h0000_1122, 1'b0);
    do_req(0, 1'b1, 3'b001, 32'h62, 32'h0000_8001,   1'b1, 32'h0000_0000, 1'b0);
    do_req(0, 1'b0, 3'b001, 32'h62, 32'd0,           1'b1, 32'hFFFF_8001, 1'b0);
    do_req(0, 1'b0, 3'b101, 32'h62, 32'd0,           1'b1, 32'h0000_8001, 1'b0);
    // Faulting accesses must leave word 0x60 alone
    do_req(0, 1'b1, 3'b001, 32'h63, 32'hFFFF_FFFF,   1'b1, 32'h0000_0000, 1'b1);
    do_req(0, 1'b1, 3'b010, 32'h62, 32'hFFFF_FFFF,   1'b1, 32'h0000_0000, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h400, 32'd0,          1'b1, 32'h0000_0000, 1'b1);
    do_req(0, 1'b0, 3'b011, 32'h60, 32'd0,           1'b1, 32'h0000_0000, 1'b1);
    do_req(0, 1'b1, 3'b100, 32'h60, 32'hFFFF_FFFF,   1'b1, 32'h0000_0000, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h60, 32'd0,           1'b1, 32'h8001_AB44, 1'b0);

    // Reset during WAIT drops the store
    do_req(0, 1'b1, 3'b010, 32'h70, 32'h0123_4567,   1'b1, 32'h0000_0000, 1'b0);
    drv_req[0] = 1'b1; drv_we[0] = 1'b1; drv_f3[0] = 3'b010; drv_addr[0] = 32'h70; drv_wd[0] = 32'hDEAD_BEEF;
    step();
    drv_req[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 0, 32'(d_busy(0)), 32'd0);
    chk("rst_rv",   0, 32'(d_rv(0)),   32'd0);
    step();
    do_req(0, 1'b0, 3'b010, 32'h70, 32'd0,           1'b1, 32'h0123_4567, 1'b0);

    // LATENCY=1 with req held high: one accept every second edge
    do_req(1, 1'b1, 3'b010, 32'h80, 32'hCAFE_F00D,   1'b1, 32'h0000_0000, 1'b0);
    pulses = 0;
    drv_req[1] = 1'b1; drv_we[1] = 1'b0; drv_f3[1] = 3'b010; drv_addr[1] = 32'h80;
    for (int n = 0; n < 10; n++) begin
      step();
      if (d_rv(1) === 1'b1) pulses++;
      if (d_rv(1) === 1'b1) chk("b2b_rdata", 1, d_rdata(1), 32'hCAFE_F00D);
    end
    drv_req[1] = 1'b0;
    chk("b2b_pulses", 1, 32'(pulses), 32'd5);
    step();

    // Random traffic on both instances, including don't-care inputs while busy and rare resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 64 == 0);
      for (int i = 0; i < 2; i++) begin
        drv_req[i]  = 1'($urandom % 2);
        drv_we[i]   = 1'($urandom % 2);
        drv_f3[i]   = 3'($urandom % 8);
        drv_addr[i] = ($urandom % 4 != 0) ? 32'($urandom_range(0, 4 * DEPTH - 1)) : $urandom;
        drv_wd[i]   = $urandom;
      end
      step();
    end
    rst = 1'b0;
    drv_req[0] = 1'b0;
    drv_req[1] = 1'b0;
    step();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
